// File: rtl/pe_accum.sv
// pe_accum: output-side accumulator for the 16-lane int8 dot-product PE.
//
// Sums a group of signed 32-bit dot products (delimited by first/last) into
// an ACC_W-bit two's-complement accumulator. On the last beat the sum is
// saturated to signed 32 bits, ReLU is optionally applied, and the result is
// queued in a 2-entry output FIFO.
//
// Ports:
//   clock      in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   ivalid     in   input beat valid
//   oready     out  block can accept an input beat (FIFO not full)
//   iready     in   downstream can accept a result
//   ovalid     out  result valid (FIFO not empty)
//   dot_accum  in   signed dot product for this beat
//   first      in   beat starts a new group
//   last       in   beat ends the group
//   relu_en    in   apply ReLU to the group result (sampled on last beat)
//   result     out  FIFO head: saturated group result
//   result_sat out  FIFO head: result was saturated
module pe_accum #(
    parameter int ACC_W      = 40,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ivalid,
    output logic        oready,
    input  logic        iready,
    output logic        ovalid,
    input  logic [31:0] dot_accum,
    input  logic        first,
    input  logic        last,
    input  logic        relu_en,
    output logic [31:0] result,
    output logic        result_sat
);

    localparam logic [1:0] CNT_FULL = 2'd2;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0][31:0] mem_q, mem_d;
    logic [1:0]       sat_q, sat_d;

    logic             acc_fire, pop, push;
    logic [ACC_W-1:0] sum;
    logic [31:0]      sat_val, push_val;
    logic             push_sat;

    // Flow control depends only on the registered count, never on iready.
    assign oready   = (cnt_q != CNT_FULL);
    assign ovalid   = (cnt_q != 2'd0);
    assign acc_fire = ivalid & oready;
    assign pop      = ovalid & iready;
    assign push     = acc_fire & last;

    assign result     = mem_q[rd_ptr_q];
    assign result_sat = sat_q[rd_ptr_q];

    always_comb begin
        sum = (first ? '0 : acc_q) + {{(ACC_W-32){dot_accum[31]}}, dot_accum};

        // The sum fits in 32 bits exactly when bits [ACC_W-1:31] all match
        // the sign; otherwise clamp toward the sign of the full sum.
        sat_val  = sum[31:0];
        push_sat = 1'b0;
        if (!(&sum[ACC_W-1:31]) && (|sum[ACC_W-1:31])) begin
            push_sat = 1'b1;
            sat_val  = sum[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end

        // ReLU acts on the clamped value; the saturation flag is kept.
        push_val = (relu_en && sat_val[31]) ? 32'd0 : sat_val;
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        sat_d    = sat_q;

        if (acc_fire) begin
            acc_d = last ? '0 : sum;
        end

        if (push) begin
            mem_d[wr_ptr_q] = push_val;
            sat_d[wr_ptr_q] = push_sat;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Push cannot happen when full (oready=0); pop cannot happen when
        // empty, so a push into an empty FIFO is never bypassed.
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q    <= '0;
            sat_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_pe_accum.sv
// Directed bench for pe_accum: inputs change #1 after the rising edge and
// outputs are sampled there, so each step sees the state after one edge.
module tb_pe_accum;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ivalid;
    logic        oready;
    logic        iready;
    logic        ovalid;
    logic [31:0] dot_accum;
    logic        first;
    logic        last;
    logic        relu_en;
    logic [31:0] result;
    logic        result_sat;

    int n_tests = 0;
    int n_fail  = 0;

    pe_accum #(.ACC_W(40), .FIFO_DEPTH(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ivalid     (ivalid),
        .oready     (oready),
        .iready     (iready),
        .ovalid     (ovalid),
        .dot_accum  (dot_accum),
        .first      (first),
        .last       (last),
        .relu_en    (relu_en),
        .result     (result),
        .result_sat (result_sat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one beat for exactly one edge, then drop ivalid.
    task automatic beat(input logic [31:0] d, input logic f, input logic l, input logic r);
        ivalid    = 1'b1;
        dot_accum = d;
        first     = f;
        last      = l;
        relu_en   = r;
        step();
        ivalid    = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
    endtask

    task automatic idle(input int n);
        ivalid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_head(input string tag, input logic [31:0] r, input logic s);
        chk({tag, "_ovalid"}, {63'd0, ovalid}, 64'd1);
        chk({tag, "_result"}, {32'd0, result}, {32'd0, r});
        chk({tag, "_sat"}, {63'd0, result_sat}, {63'd0, s});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_ovalid0"}, {63'd0, ovalid}, 64'd0);
        chk({tag, "_oready1"}, {63'd0, oready}, 64'd1);
    endtask

    initial begin
        resetn    = 1'b0;
        ivalid    = 1'b0;
        iready    = 1'b1;
        dot_accum = '0;
        first     = 1'b0;
        last      = 1'b0;
        relu_en   = 1'b0;
        #3;
        chk_empty("reset");
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_sat", {63'd0, result_sat}, 64'd0);
        step();
        resetn = 1'b1;
        step();

        // Four-beat group: 10 + 20 - 5 + 7 = 32.
        beat(32'd10, 1, 0, 0);
        beat(32'd20, 0, 0, 0);
        beat(-32'sd5, 0, 0, 0);
        chk("grp4_pre_ovalid", {63'd0, ovalid}, 64'd0);
        beat(32'd7, 0, 1, 0);
        chk_head("grp4", 32'd32, 1'b0);
        idle(1);
        chk_empty("grp4_drained");

        // One-beat groups; second push coincides with the pop of the first.
        beat(-32'sd3, 1, 1, 1);
        chk_head("one_relu", 32'd0, 1'b0);
        beat(-32'sd3, 1, 1, 0);
        chk_head("one_norelu", 32'hFFFF_FFFD, 1'b0);
        chk("pushpop_oready", {63'd0, oready}, 64'd1);
        idle(1);
        chk_empty("one_drained");

        // Positive overflow: 3 * (2^31-1).
        beat(32'h7FFF_FFFF, 1, 0, 0);
        beat(32'h7FFF_FFFF, 0, 0, 0);
        beat(32'h7FFF_FFFF, 0, 1, 0);
        chk_head("sat_pos", 32'h7FFF_FFFF, 1'b1);
        idle(1);
        // Negative overflow: 2 * -2^31 = -2^32.
        beat(32'h8000_0000, 1, 0, 0);
        beat(32'h8000_0000, 0, 1, 0);
        chk_head("sat_neg", 32'h8000_0000, 1'b1);
        idle(1);
        beat(32'h7FFF_FFFF, 1, 0, 1);
        beat(32'h7FFF_FFFF, 0, 0, 1);
        beat(32'h7FFF_FFFF, 0, 1, 1);
        chk_head("sat_pos_relu", 32'h7FFF_FFFF, 1'b1);
        idle(1);
        beat(32'h8000_0000, 1, 0, 1);
        beat(32'h8000_0000, 0, 1, 1);
        chk_head("sat_neg_relu", 32'd0, 1'b1);
        idle(1);
        chk_empty("sat_drained");

        // Backpressure: fill with 1 and 2, then 3 stalls.
        iready = 1'b0;
        beat(32'd1, 1, 1, 0);
        chk("bp_oready_c1", {63'd0, oready}, 64'd1);
        beat(32'd2, 1, 1, 0);
        chk("bp_oready_full", {63'd0, oready}, 64'd0);
        ivalid = 1'b1; dot_accum = 32'd3; first = 1'b1; last = 1'b1; relu_en = 1'b0;
        step();
        chk("bp_stall_oready", {63'd0, oready}, 64'd0);
        chk_head("bp_head_hold", 32'd1, 1'b0);
        iready = 1'b1;
        step();
        chk_head("bp_out2", 32'd2, 1'b0);
        chk("bp_oready_rise", {63'd0, oready}, 64'd1);
        step();                               // push 3 while popping 2 at count 1
        ivalid = 1'b0;
        chk_head("bp_out3", 32'd3, 1'b0);
        chk("bp_cnt1_oready", {63'd0, oready}, 64'd1);
        idle(1);
        chk_empty("bp_drained");

        // Gapped group: 100 - 40 + 7 + 1000 - 3 = 1064.
        beat(32'd100, 1, 0, 0);
        idle($urandom_range(0, 3));
        beat(-32'sd40, 0, 0, 0);
        idle($urandom_range(0, 3));
        beat(32'd7, 0, 0, 0);
        idle($urandom_range(0, 3));
        beat(32'd1000, 0, 0, 0);
        idle($urandom_range(0, 3));
        chk("gap_pre_ovalid", {63'd0, ovalid}, 64'd0);
        beat(-32'sd3, 0, 1, 0);
        chk_head("gap", 32'd1064, 1'b0);
        idle(1);
        // No first after a last: starts from 0.
        beat(32'd6, 0, 1, 0);
        chk_head("nofirst", 32'd6, 1'b0);
        idle(1);

        // Reset with two results queued.
        iready = 1'b0;
        beat(32'd11, 1, 1, 0);
        beat(32'd22, 1, 1, 0);
        chk("rst_q_full", {63'd0, oready}, 64'd0);
        resetn = 1'b0;
        #1;
        chk_empty("rst_q");
        chk("rst_q_result", {32'd0, result}, 64'd0);
        step();
        resetn = 1'b1;
        iready = 1'b1;
        // Reset mid-group discards the partial 50.
        beat(32'd50, 1, 0, 0);
        resetn = 1'b0;
        #1;
        chk_empty("rst_mid");
        step();
        resetn = 1'b1;
        beat(32'd4, 0, 0, 0);
        beat(32'd5, 0, 1, 0);
        chk_head("post_rst", 32'd9, 1'b0);
        idle(1);
        chk_empty("post_rst_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
